// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned num_chunks(input int unsigned width,
                                               input int unsigned chunk);
        return width / chunk;
    endfunction

    // Chunk index register needs at least one bit even when N=1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB.
module chunk_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit add/subtract through one shared CHUNK-bit slice, LSB first.
// Define SATURATE_EN to clamp overflowing results to the signed limit.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int unsigned N  = num_chunks(WIDTH, CHUNK);
    localparam int unsigned IW = idx_width(N);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_cout, sl_cmsb;
    int unsigned      lo;

    // b_q already holds ~b for subtraction, so the slice only ever adds.
    assign lo   = 32'(idx_q) * CHUNK;
    assign sl_a = a_q[lo +: CHUNK];
    assign sl_b = b_q[lo +: CHUNK];

    chunk_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry_q),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[lo +: CHUNK] = sl_s;
                carry_d            = sl_cout;
                if (idx_q == IW'(N - 1)) begin
                    co_d    = sl_cout;
                    ov_d    = sl_cmsb ^ sl_cout;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SATURATE_EN
                    if (sl_cmsb ^ sl_cout) begin
                        sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`else
`endif
                end else begin
                    idx_d  = idx_q + IW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carryout = co_q;
    assign overflow = ov_q;

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
Parametrised multi-cycle two's-complement adder/subtractor. Processes WIDTH-bit operands CHUNK bits per cycle, LSB chunk first, through one shared CHUNK-bit ripple slice. Reports carryout and signed overflow for the full WIDTH result. Intended as a low-area arithmetic unit behind a start/done handshake, and as the wide successor to the team's fixed 4-bit full adder.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK and >= CHUNK.
CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  request; sampled only when busy=0 or done=1.
sub  input  1  0 = a+b, 1 = a-b; latched with operands.
a  input  WIDTH  operand A, latched on accepted start.
b  input  WIDTH  operand B, latched on accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when result is valid.
sum  output  WIDTH  result; held from done until the next accepted start.
carryout  output  1  carry out of bit WIDTH-1; held with sum.
overflow  output  1  signed overflow flag; held with sum.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; busy=0, done=0, sum=0, carryout=0, overflow=0; chunk index=0; latched operands cleared. Reset has priority over everything and aborts an operation in progress with no done pulse.
- States and transitions:
  - IDLE: start=1 latches a, b, sub; carry_in = sub; index=0; go to RUN.
  - RUN: each cycle adds chunk[index] of A and chunk[index] of (sub ? ~B : B) plus the carry register. Writes that chunk of sum and stores carry. On index=N-1, captures carryout = slice carry out and overflow = (carry into bit WIDTH-1) XOR carryout, then goes to DONE. Otherwise index increments.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted (back-to-back, same as IDLE→RUN); otherwise go to IDLE.
- busy=1 in RUN only.
- Latency: start accepted at edge t; done high in cycle t+N; sum, carryout and overflow are valid from that cycle.
- start while in RUN is ignored, with no queueing. a, b and sub changing during RUN have no effect.
- sum is updated chunk-wise during RUN. Consumers may sample it only on done or later. Intermediate values are not specified to the verification bench.
- Subtraction: carryout=1 means no borrow (a >= b unsigned). The overflow rule is identical for add and subtract.
- N=1 (CHUNK=WIDTH): a single RUN cycle, done at t+1.

Optional Feature:
SATURATE_EN
- Defined: on overflow=1, sum is replaced in the DONE cycle by the signed limit. Use 0111…1 when operand A's sign bit=0, and 1000…0 when it is 1. carryout and overflow are still reported unsaturated.
- Undefined: sum is the wrapped modulo-2^WIDTH result.

Decomposition:
- Package adder_pkg: state enum (IDLE, RUN, DONE); localparam helper for N and the index width ($clog2(N), minimum 1).
- Sub-module chunk_slice: combinational CHUNK-bit ripple adder. Inputs a, b, cin. Outputs s, cout, and c_msb (carry into the slice MSB, used for overflow). Instantiated once.

Test Plan:
(WIDTH=16, CHUNK=4 unless noted; each check taken on the done cycle, which must be cycle t+4.)
1. a=0x0003, b=0x0005, sub=0 → sum=0x0008, carryout=0, overflow=0.
2. a=0xFFFF, b=0xFFFF, sub=0 → sum=0xFFFE, carryout=1, overflow=0.
3. a=0x7FFF, b=0x0001 → sum=0x8000, carryout=0, overflow=1 (SATURATE_EN: sum=0x7FFF). Then a=0x8000, b=0xFFFF → sum=0x7FFF, carryout=1, overflow=1 (SATURATE_EN: 0x8000).
4. Subtract, sub=1:
   - a=0x0005, b=0x0007 → sum=0xFFFE, carryout=0, overflow=0.
   - a=0x8000, b=0x0001 → sum=0x7FFF, carryout=1, overflow=1.
5. Handshake:
   - start pulsed again during RUN with different operands → ignored; first result unchanged.
   - start held high in the DONE cycle → second operation's done arrives exactly 4 cycles later.
   - Results persist unchanged across 10 idle cycles.
6. Reset mid-operation: rst_n=0 at cycle 2 of RUN → next edge busy=0, done=0, sum=0, flags=0, and no done pulse follows. A subsequent start of 0x1234+0x1111 → 0x2345 on schedule. Repeat case 1 with CHUNK=16 (N=1) → done at t+1.
